// File: rtl/i2c_share_arbiter_if.sv
// Requester-side and core-side signal bundle for the I2C share arbiter.
// The slave modport is the arbiter's view; master is the view of whatever
// surrounds it (requester FSMs and the I2C master core).
interface i2c_share_arbiter_if;
  logic [1:0]  req_write_i;
  logic [1:0]  req_read_i;
  logic [15:0] req_slave_addr_i;
  logic [15:0] req_command_byte_i;
  logic [15:0] req_din_i;
  logic [15:0] req_num_bytes_i;
  logic [1:0]  req_busy_o;
  logic [1:0]  req_done_o;
  logic [1:0]  req_err_o;
  logic [15:0] req_rd_data_o;
  logic        core_busy_i;
  logic        core_rxak_i;
  logic        core_arb_lost_i;
  logic        core_data_out_valid_i;
  logic [7:0]  core_data_out_i;
  logic        core_write_o;
  logic        core_read_o;
  logic [7:0]  core_slave_addr_o;
  logic [7:0]  core_command_byte_o;
  logic [7:0]  core_din_o;
  logic [7:0]  core_num_bytes_o;

  modport slave (
    input  req_write_i, req_read_i, req_slave_addr_i, req_command_byte_i,
           req_din_i, req_num_bytes_i,
           core_busy_i, core_rxak_i, core_arb_lost_i, core_data_out_valid_i,
           core_data_out_i,
    output req_busy_o, req_done_o, req_err_o, req_rd_data_o,
           core_write_o, core_read_o, core_slave_addr_o, core_command_byte_o,
           core_din_o, core_num_bytes_o
  );

  modport master (
    output req_write_i, req_read_i, req_slave_addr_i, req_command_byte_i,
           req_din_i, req_num_bytes_i,
           core_busy_i, core_rxak_i, core_arb_lost_i, core_data_out_valid_i,
           core_data_out_i,
    input  req_busy_o, req_done_o, req_err_o, req_rd_data_o,
           core_write_o, core_read_o, core_slave_addr_o, core_command_byte_o,
           core_din_o, core_num_bytes_o
  );
endinterface

// File: rtl/i2c_share_arbiter.sv
// Round-robin arbiter sharing one I2C master core between two requester FSMs.
// Each requester gets a one-deep pending slot; the winner's fields are
// registered onto the core, and done/error/read data go back to that owner only.
module i2c_share_arbiter #(
  parameter int START_TIMEOUT = 16,
  parameter int TO_W          = 5
) (
  input logic            clk_i,
  input logic            reset_i,
  i2c_share_arbiter_if.slave bus
);

  typedef enum logic [2:0] {IDLE, ISSUE, WAIT_START, WAIT_END, DONE} state_t;

  state_t            r_state;
  state_t            w_stateNext;

  logic [1:0]        r_pend;
  logic [1:0]        r_pendWr;
  logic [1:0][7:0]   r_addr;
  logic [1:0][7:0]   r_cmd;
  logic [1:0][7:0]   r_din;
  logic [1:0][7:0]   r_nb;

  logic              r_owner;
  logic              r_ownWr;
  logic              r_ptr;
  logic              r_flag;
  logic [TO_W-1:0]   r_cnt;
  logic [1:0]        r_err;
  logic [1:0][7:0]   r_rdData;
  logic [7:0]        r_coreAddr;
  logic [7:0]        r_coreCmd;
  logic [7:0]        r_coreDin;
  logic [7:0]        r_coreNb;

  logic [1:0]        w_strobe;
  logic              w_grant;
  logic [TO_W-1:0]   w_cntNext;
  logic              w_timeout;
  logic              w_doneErr;
  logic              w_coreWrite;
  logic              w_coreRead;
  logic [1:0]        w_done;
  logic [1:0]        w_errOut;

  assign w_strobe  = bus.req_write_i | bus.req_read_i;
  assign w_grant   = (r_pend == 2'b11) ? r_ptr : r_pend[1];
  assign w_cntNext = r_cnt + 1'b1;
  assign w_timeout = (w_cntNext == TO_W'(START_TIMEOUT));
  // rxak high on a read is the master's own final NACK, so only writes treat it as an error
  assign w_doneErr = r_flag | bus.core_arb_lost_i | (r_ownWr & bus.core_rxak_i);

  // State register
  always_ff @(posedge clk_i) begin
    if (reset_i) r_state <= IDLE;
    else         r_state <= w_stateNext;
  end

  // Next-state logic and the outputs that are decoded from the current state
  always_comb begin
    w_stateNext = r_state;
    w_coreWrite = 1'b0;
    w_coreRead  = 1'b0;
    w_done      = 2'b00;
    w_errOut    = r_err;
    case (r_state)
      IDLE: begin
        if ((r_pend != 2'b00) && !bus.core_busy_i) w_stateNext = ISSUE;
      end
      ISSUE: begin
        w_coreWrite = r_ownWr;
        w_coreRead  = ~r_ownWr;
        w_stateNext = WAIT_START;
      end
      WAIT_START: begin
        if (bus.core_busy_i)  w_stateNext = WAIT_END;
        else if (w_timeout)   w_stateNext = DONE;
      end
      WAIT_END: begin
        if (!bus.core_busy_i) w_stateNext = DONE;
      end
      DONE: begin
        w_done[r_owner]   = 1'b1;
        w_errOut[r_owner] = w_doneErr;
        w_stateNext       = IDLE;
      end
      default: w_stateNext = IDLE;
    endcase
  end

  // Pending slots: capture a strobe only when the slot is free, free it in DONE
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_pend   <= '0;
      r_pendWr <= '0;
      r_addr   <= '0;
      r_cmd    <= '0;
      r_din    <= '0;
      r_nb     <= '0;
    end else begin
      if (r_state == DONE) r_pend[r_owner] <= 1'b0;
      for (int i = 0; i < 2; i++) begin
        if (w_strobe[i] && !r_pend[i]) begin
          r_pend[i]   <= 1'b1;
          r_pendWr[i] <= bus.req_write_i[i];
          r_addr[i]   <= bus.req_slave_addr_i[8*i +: 8];
          r_cmd[i]    <= bus.req_command_byte_i[8*i +: 8];
          r_din[i]    <= bus.req_din_i[8*i +: 8];
          r_nb[i]     <= bus.req_num_bytes_i[8*i +: 8];
        end
      end
    end
  end

  // Grant: pick the owner, register its fields onto the core, rotate pointer in DONE
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_owner    <= 1'b0;
      r_ownWr    <= 1'b0;
      r_ptr      <= 1'b0;
      r_coreAddr <= '0;
      r_coreCmd  <= '0;
      r_coreDin  <= '0;
      r_coreNb   <= '0;
    end else if (r_state == IDLE && w_stateNext == ISSUE) begin
      r_owner    <= w_grant;
      r_ownWr    <= r_pendWr[w_grant];
      r_coreAddr <= r_addr[w_grant];
      r_coreCmd  <= r_cmd[w_grant];
      r_coreDin  <= r_din[w_grant];
      r_coreNb   <= r_nb[w_grant];
    end else if (r_state == DONE) begin
      r_ptr <= ~r_owner;
    end
  end

  // Start timeout counter and sticky error flag for the transaction in flight
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_cnt  <= '0;
      r_flag <= 1'b0;
    end else begin
      case (r_state)
        ISSUE: begin
          r_cnt  <= '0;
          r_flag <= 1'b0;
        end
        WAIT_START: begin
          r_cnt <= w_cntNext;
          if (!bus.core_busy_i && w_timeout) r_flag <= 1'b1;
        end
        WAIT_END: begin
          if (bus.core_arb_lost_i) r_flag <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Per-requester status: read byte captured during the transfer, error held between dones
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_err    <= '0;
      r_rdData <= '0;
    end else begin
      if (r_state == WAIT_END && !r_ownWr && bus.core_data_out_valid_i)
        r_rdData[r_owner] <= bus.core_data_out_i;
      if (r_state == DONE)
        r_err[r_owner] <= w_doneErr;
    end
  end

  assign bus.req_busy_o          = r_pend;
  assign bus.req_done_o          = w_done;
  assign bus.req_err_o           = w_errOut;
  assign bus.req_rd_data_o       = r_rdData;
  assign bus.core_write_o        = w_coreWrite;
  assign bus.core_read_o         = w_coreRead;
  assign bus.core_slave_addr_o   = r_coreAddr;
  assign bus.core_command_byte_o = r_coreCmd;
  assign bus.core_din_o          = r_coreDin;
  assign bus.core_num_bytes_o    = r_coreNb;

endmodule

// File: tb/tb_i2c_share_arbiter.sv
// Directed bench for i2c_share_arbiter: a small behavioural I2C core answers
// the arbiter's strobes, and each scenario task checks its own expectations.
module tb_i2c_share_arbiter;

  logic clk;
  logic reset;
  int   nChecks;
  int   nFails;

  // Knobs for the behavioural core, set by each scenario before its strobe
  bit         cfgNoBusy;
  int         cfgBusyLen;
  int         cfgArbAt;
  int         cfgDvAt;
  logic       cfgRxak;
  logic [7:0] cfgData;

  i2c_share_arbiter_if bus();

  i2c_share_arbiter #(.START_TIMEOUT(16), .TO_W(5)) dut (
    .clk_i   (clk),
    .reset_i (reset),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural core: raises busy when it sees a strobe, holds it cfgBusyLen+1
  // cycles, optionally pulses arb_lost / data valid, and drives rxak on release
  initial begin : coreModel
    bus.core_busy_i           = 1'b0;
    bus.core_rxak_i           = 1'b0;
    bus.core_arb_lost_i       = 1'b0;
    bus.core_data_out_valid_i = 1'b0;
    bus.core_data_out_i       = 8'h00;
    forever begin
      @(negedge clk);
      if ((bus.core_write_o || bus.core_read_o) && !cfgNoBusy) begin
        bus.core_busy_i = 1'b1;
        bus.core_rxak_i = 1'b0;
        for (int i = 0; i < cfgBusyLen; i++) begin
          @(negedge clk);
          bus.core_arb_lost_i       = (i == cfgArbAt);
          bus.core_data_out_valid_i = (i == cfgDvAt);
          bus.core_data_out_i       = cfgData;
        end
        @(negedge clk);
        bus.core_arb_lost_i       = 1'b0;
        bus.core_data_out_valid_i = 1'b0;
        bus.core_busy_i           = 1'b0;
        bus.core_rxak_i           = cfgRxak;
      end
    end
  end

  task automatic setCore(input bit noBusy, input int busyLen, input int arbAt,
                         input int dvAt, input logic rxak, input logic [7:0] data);
    cfgNoBusy  = noBusy;
    cfgBusyLen = busyLen;
    cfgArbAt   = arbAt;
    cfgDvAt    = dvAt;
    cfgRxak    = rxak;
    cfgData    = data;
  endtask

  // Drive one requester strobe for one cycle, starting at a falling edge
  task automatic pulseReq(input int r, input logic wr, input logic rd,
                          input logic [7:0] addr, input logic [7:0] cmd,
                          input logic [7:0] din, input logic [7:0] nb);
    bus.req_slave_addr_i[8*r +: 8]   = addr;
    bus.req_command_byte_i[8*r +: 8] = cmd;
    bus.req_din_i[8*r +: 8]          = din;
    bus.req_num_bytes_i[8*r +: 8]    = nb;
    bus.req_write_i[r] = wr;
    bus.req_read_i[r]  = rd;
    @(negedge clk);
    bus.req_write_i = 2'b00;
    bus.req_read_i  = 2'b00;
  endtask

  // Wait (bounded) for a done pulse; cyc counts falling edges from the call
  task automatic waitDone(input int maxCyc, output bit found, output int cyc,
                          output logic [1:0] doneV, output logic [1:0] errV);
    found = 1'b0;
    cyc   = 0;
    doneV = 2'b00;
    errV  = 2'b00;
    for (int i = 1; i <= maxCyc && !found; i++) begin
      @(negedge clk);
      if (bus.req_done_o != 2'b00) begin
        found = 1'b1;
        cyc   = i;
        doneV = bus.req_done_o;
        errV  = bus.req_err_o;
      end
    end
  endtask

  task automatic resetDut();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    nChecks++;
    if ({bus.req_busy_o, bus.req_done_o, bus.req_err_o} !== 6'b0) begin
      nFails++;
      $display("[TB] FAIL reset_status: got busy/done/err %b required 000000",
               {bus.req_busy_o, bus.req_done_o, bus.req_err_o});
    end
    nChecks++;
    if (bus.req_rd_data_o !== 16'h0000) begin
      nFails++;
      $display("[TB] FAIL reset_rd_data: got %h required 0000", bus.req_rd_data_o);
    end
    nChecks++;
    if ({bus.core_write_o, bus.core_read_o, bus.core_slave_addr_o, bus.core_command_byte_o,
         bus.core_din_o, bus.core_num_bytes_o} !== 34'h0) begin
      nFails++;
      $display("[TB] FAIL reset_core: got w=%b r=%b fields %h %h %h %h required all zero",
               bus.core_write_o, bus.core_read_o, bus.core_slave_addr_o,
               bus.core_command_byte_o, bus.core_din_o, bus.core_num_bytes_o);
    end
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_write();
    bit found; int cyc; logic [1:0] dv, ev;
    setCore(1'b0, 2, -1, -1, 1'b0, 8'h00);
    pulseReq(0, 1'b1, 1'b0, 8'hD0, 8'h6B, 8'h00, 8'h02);
    nChecks++;
    if (bus.req_busy_o !== 2'b01 || bus.core_write_o !== 1'b0) begin
      nFails++;
      $display("[TB] FAIL write_t1: got busy=%b core_write=%b required 01 0",
               bus.req_busy_o, bus.core_write_o);
    end
    @(negedge clk);
    nChecks++;
    if (bus.core_write_o !== 1'b1 || bus.core_read_o !== 1'b0) begin
      nFails++;
      $display("[TB] FAIL write_strobe_t2: got w=%b r=%b required 1 0",
               bus.core_write_o, bus.core_read_o);
    end
    nChecks++;
    if ({bus.core_slave_addr_o, bus.core_command_byte_o, bus.core_din_o,
         bus.core_num_bytes_o} !== 32'hD06B0002) begin
      nFails++;
      $display("[TB] FAIL write_fields: got %h%h%h%h required D06B0002",
               bus.core_slave_addr_o, bus.core_command_byte_o, bus.core_din_o,
               bus.core_num_bytes_o);
    end
    waitDone(40, found, cyc, dv, ev);
    nChecks++;
    if (found !== 1'b1 || cyc != 4 || dv !== 2'b01 || ev[0] !== 1'b0) begin
      nFails++;
      $display("[TB] FAIL write_done: got found=%0d cyc=%0d done=%b err=%b required 1 4 01 x0",
               found, cyc, dv, ev);
    end
    @(negedge clk);
    nChecks++;
    if (bus.req_busy_o !== 2'b00 || bus.req_done_o !== 2'b00) begin
      nFails++;
      $display("[TB] FAIL write_release: got busy=%b done=%b required 00 00",
               bus.req_busy_o, bus.req_done_o);
    end
  endtask

  task automatic test_read();
    bit found; int cyc; logic [1:0] dv, ev;
    setCore(1'b0, 3, -1, 1, 1'b1, 8'hF9);
    pulseReq(1, 1'b0, 1'b1, 8'hD0, 8'h3D, 8'h00, 8'h02);
    @(negedge clk);
    nChecks++;
    if (bus.core_read_o !== 1'b1 || bus.core_write_o !== 1'b0 ||
        bus.core_command_byte_o !== 8'h3D) begin
      nFails++;
      $display("[TB] FAIL read_strobe: got r=%b w=%b cmd=%h required 1 0 3D",
               bus.core_read_o, bus.core_write_o, bus.core_command_byte_o);
    end
    waitDone(40, found, cyc, dv, ev);
    nChecks++;
    if (found !== 1'b1 || cyc != 5 || dv !== 2'b10 || ev[1] !== 1'b0) begin
      nFails++;
      $display("[TB] FAIL read_done: got found=%0d cyc=%0d done=%b err=%b required 1 5 10 0x",
               found, cyc, dv, ev);
    end
    nChecks++;
    if (bus.req_rd_data_o !== 16'hF900) begin
      nFails++;
      $display("[TB] FAIL read_data: got %h required F900", bus.req_rd_data_o);
    end
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    int order[4];
    int grants;
    int restrikes;
    logic [1:0] restrobe;
    resetDut();
    setCore(1'b0, 2, -1, -1, 1'b0, 8'h00);
    grants    = 0;
    restrikes = 0;
    restrobe  = 2'b00;
    bus.req_slave_addr_i   = 16'hD2D0;
    bus.req_command_byte_i = 16'h2211;
    bus.req_din_i          = 16'hB0A0;
    bus.req_num_bytes_i    = 16'h0202;
    bus.req_write_i        = 2'b11;
    for (int k = 0; k < 300 && grants < 4; k++) begin
      @(negedge clk);
      bus.req_write_i = restrobe;
      restrobe        = 2'b00;
      if (bus.req_done_o != 2'b00) begin
        order[grants] = bus.req_done_o[1] ? 1 : 0;
        grants++;
        if (restrikes < 2) begin
          restrobe[order[grants-1]] = 1'b1;
          restrikes++;
        end
      end
    end
    bus.req_write_i = 2'b00;
    nChecks++;
    if (grants != 4 || order[0] != 0 || order[1] != 1 || order[2] != 0 || order[3] != 1) begin
      nFails++;
      $display("[TB] FAIL b2b_order: got %0d grants order %0d%0d%0d%0d required 4 grants 0101",
               grants, order[0], order[1], order[2], order[3]);
    end
    @(negedge clk);
    nChecks++;
    if (bus.req_busy_o !== 2'b00) begin
      nFails++;
      $display("[TB] FAIL b2b_drain: got busy=%b required 00", bus.req_busy_o);
    end
  endtask

  task automatic test_timeout();
    bit found; int cyc; logic [1:0] dv, ev;
    setCore(1'b1, 0, -1, -1, 1'b0, 8'h00);
    pulseReq(0, 1'b1, 1'b0, 8'hD0, 8'h10, 8'h20, 8'h02);
    waitDone(60, found, cyc, dv, ev);
    nChecks++;
    if (found !== 1'b1 || cyc != 18 || dv !== 2'b01 || ev[0] !== 1'b1) begin
      nFails++;
      $display("[TB] FAIL timeout_done: got found=%0d cyc=%0d done=%b err=%b required 1 18 01 x1",
               found, cyc, dv, ev);
    end
    @(negedge clk);
    nChecks++;
    if (bus.req_busy_o !== 2'b00 || bus.req_done_o !== 2'b00 || bus.core_write_o !== 1'b0) begin
      nFails++;
      $display("[TB] FAIL timeout_idle: got busy=%b done=%b w=%b required 00 00 0",
               bus.req_busy_o, bus.req_done_o, bus.core_write_o);
    end
    cfgNoBusy = 1'b0;
  endtask

  task automatic test_errors();
    bit found; int cyc; logic [1:0] dv, ev;
    // write with arbitration lost mid-transfer
    setCore(1'b0, 3, 1, -1, 1'b0, 8'h00);
    pulseReq(0, 1'b1, 1'b0, 8'hD0, 8'h6B, 8'h01, 8'h02);
    waitDone(40, found, cyc, dv, ev);
    nChecks++;
    if (found !== 1'b1 || dv !== 2'b01 || ev[0] !== 1'b1) begin
      nFails++;
      $display("[TB] FAIL err_arblost: got found=%0d done=%b err=%b required 1 01 x1",
               found, dv, ev);
    end
    @(negedge clk);
    nChecks++;
    if (bus.req_err_o[0] !== 1'b1) begin
      nFails++;
      $display("[TB] FAIL err_hold: got err0=%b required 1", bus.req_err_o[0]);
    end
    // write NACKed by the slave
    setCore(1'b0, 2, -1, -1, 1'b1, 8'h00);
    pulseReq(0, 1'b1, 1'b0, 8'hD0, 8'h6B, 8'h02, 8'h02);
    waitDone(40, found, cyc, dv, ev);
    nChecks++;
    if (found !== 1'b1 || dv !== 2'b01 || ev[0] !== 1'b1) begin
      nFails++;
      $display("[TB] FAIL err_wr_nack: got found=%0d done=%b err=%b required 1 01 x1",
               found, dv, ev);
    end
    @(negedge clk);
    // read ending with NACK is normal
    setCore(1'b0, 2, -1, -1, 1'b1, 8'h00);
    pulseReq(0, 1'b0, 1'b1, 8'hD0, 8'h3D, 8'h00, 8'h02);
    waitDone(40, found, cyc, dv, ev);
    nChecks++;
    if (found !== 1'b1 || dv !== 2'b01 || ev[0] !== 1'b0) begin
      nFails++;
      $display("[TB] FAIL err_rd_nack: got found=%0d done=%b err=%b required 1 01 x0",
               found, dv, ev);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    bit found; int cyc; logic [1:0] dv, ev;
    setCore(1'b0, 6, -1, -1, 1'b0, 8'h00);
    pulseReq(0, 1'b1, 1'b0, 8'hD0, 8'h6B, 8'h55, 8'h02);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    nChecks++;
    if ({bus.req_busy_o, bus.req_done_o, bus.req_err_o} !== 6'b0 ||
        bus.req_rd_data_o !== 16'h0000) begin
      nFails++;
      $display("[TB] FAIL midreset_status: got busy=%b done=%b err=%b rd=%h required all zero",
               bus.req_busy_o, bus.req_done_o, bus.req_err_o, bus.req_rd_data_o);
    end
    nChecks++;
    if ({bus.core_write_o, bus.core_read_o, bus.core_slave_addr_o, bus.core_command_byte_o,
         bus.core_din_o, bus.core_num_bytes_o} !== 34'h0) begin
      nFails++;
      $display("[TB] FAIL midreset_core: got w=%b r=%b fields %h %h %h %h required all zero",
               bus.core_write_o, bus.core_read_o, bus.core_slave_addr_o,
               bus.core_command_byte_o, bus.core_din_o, bus.core_num_bytes_o);
    end
    reset = 1'b0;
    waitDone(12, found, cyc, dv, ev);
    nChecks++;
    if (found !== 1'b0) begin
      nFails++;
      $display("[TB] FAIL midreset_nodone: got done=%b after %0d cycles required none", dv, cyc);
    end
    // fresh read is served; a second strobe while busy is dropped
    setCore(1'b0, 3, -1, 1, 1'b0, 8'h3C);
    pulseReq(1, 1'b0, 1'b1, 8'hD0, 8'hAA, 8'h00, 8'h02);
    nChecks++;
    if (bus.req_busy_o !== 2'b10) begin
      nFails++;
      $display("[TB] FAIL midreset_busy: got busy=%b required 10", bus.req_busy_o);
    end
    pulseReq(1, 1'b1, 1'b0, 8'hD0, 8'hBB, 8'h77, 8'h02);
    nChecks++;
    if (bus.core_read_o !== 1'b1 || bus.core_write_o !== 1'b0 ||
        bus.core_command_byte_o !== 8'hAA) begin
      nFails++;
      $display("[TB] FAIL ignore_strobe: got r=%b w=%b cmd=%h required 1 0 AA",
               bus.core_read_o, bus.core_write_o, bus.core_command_byte_o);
    end
    waitDone(40, found, cyc, dv, ev);
    nChecks++;
    if (found !== 1'b1 || dv !== 2'b10 || ev[1] !== 1'b0 || bus.req_rd_data_o !== 16'h3C00) begin
      nFails++;
      $display("[TB] FAIL post_reset_read: got found=%0d done=%b err=%b rd=%h required 1 10 0x 3C00",
               found, dv, ev, bus.req_rd_data_o);
    end
    waitDone(30, found, cyc, dv, ev);
    nChecks++;
    if (found !== 1'b0 || bus.req_busy_o !== 2'b00) begin
      nFails++;
      $display("[TB] FAIL ignore_no_second: got found=%0d done=%b busy=%b required 0 00",
               found, dv, bus.req_busy_o);
    end
  endtask

  initial begin
    nChecks = 0;
    nFails  = 0;
    reset   = 1'b1;
    setCore(1'b0, 2, -1, -1, 1'b0, 8'h00);
    bus.req_write_i        = 2'b00;
    bus.req_read_i         = 2'b00;
    bus.req_slave_addr_i   = 16'h0000;
    bus.req_command_byte_i = 16'h0000;
    bus.req_din_i          = 16'h0000;
    bus.req_num_bytes_i    = 16'h0000;
    @(negedge clk);
    $display("[TB] starting i2c_share_arbiter scenarios");
    test_reset();
    test_write();
    test_read();
    test_back_to_back();
    test_timeout();
    test_errors();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
